// File: rtl/pref_issue_queue.sv
//==============================================================================
// Module      : pref_issue_queue
// Description : Line-aligns up to three prefetch candidates per cycle, filters
//               duplicates, queues survivors and issues one per cycle.
//               Optional macro PREF_STATS_EN enables the statistics counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pref_issue_queue #(
  parameter int ADDR_W    = 64,
  parameter int DEPTH     = 8,
  parameter int LINE_BITS = 6,
  parameter int RECENT    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable_i,
  input  logic                       flush_i,
  input  logic [ADDR_W-1:0]          pref_addr1_i,
  input  logic [ADDR_W-1:0]          pref_addr2_i,
  input  logic [ADDR_W-1:0]          pref_addr3_i,
  input  logic                       pref_valid1_i,
  input  logic                       pref_valid2_i,
  input  logic                       pref_valid3_i,
  output logic                       req_valid_o,
  output logic [ADDR_W-1:0]          req_addr_o,
  input  logic                       req_ready_i,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic [31:0]                stat_issued_o,
  output logic [31:0]                stat_drop_dup_o,
  output logic [31:0]                stat_drop_full_o
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_rec_w = (RECENT > 1) ? $clog2(RECENT) : 1;
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
  localparam logic [ADDR_W-1:0]  c_off_mask = {{(ADDR_W-LINE_BITS){1'b0}}, {LINE_BITS{1'b1}}};

  logic [ADDR_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [ADDR_W-1:0]  r_recent [RECENT];
  logic [RECENT-1:0]  r_recent_vld;
  logic [c_rec_w-1:0] r_recent_ptr;
  logic [ADDR_W-1:0]  r_last;

  logic [ADDR_W-1:0]  w_addr [3];
  logic [2:0]         w_vld;
  logic [ADDR_W-1:0]  w_line [3];
  logic [2:0]         w_cand;
  logic [2:0]         w_hit;
  logic [2:0]         w_acc;
  logic [c_ptr_w-1:0] w_slot_ptr [3];
  logic [1:0]         w_n_acc;
  logic [c_cnt_w-1:0] w_free;
  logic [c_ptr_w-1:0] w_off [DEPTH];
  logic [DEPTH-1:0]   w_fifo_vld;
  logic [ADDR_W-1:0]  w_head;
  logic               w_pop;

  assign w_addr[0] = pref_addr1_i;
  assign w_addr[1] = pref_addr2_i;
  assign w_addr[2] = pref_addr3_i;
  assign w_vld     = {pref_valid3_i, pref_valid2_i, pref_valid1_i};

  assign w_head      = r_mem[r_rd_ptr];
  assign req_valid_o = (r_count != '0);
  // Empty queue shows the previous cycle's output so the port never goes stale/X.
  assign req_addr_o  = req_valid_o ? w_head : r_last;
  assign occupancy_o = r_count;
  assign w_pop       = req_valid_o && req_ready_i;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_off[i]      = c_ptr_w'(i) - r_rd_ptr;
      w_fifo_vld[i] = ({1'b0, w_off[i]} < r_count);
    end
  end

  // Slot-ordered filtering: free space is taken before this cycle's dequeue.
  always_comb begin
    w_free  = c_depth - r_count;
    w_n_acc = '0;
    w_acc   = '0;
    w_hit   = '0;
    w_cand  = '0;
    for (int k = 0; k < 3; k++) begin
      w_line[k]     = w_addr[k] & ~c_off_mask;
      w_slot_ptr[k] = '0;
    end
    for (int k = 0; k < 3; k++) begin
      w_cand[k] = enable_i && !flush_i && w_vld[k];
      for (int j = 0; j < k; j++)
        if (w_cand[j] && (w_line[j] == w_line[k])) w_hit[k] = 1'b1;
      for (int i = 0; i < DEPTH; i++)
        if (w_fifo_vld[i] && (r_mem[i] == w_line[k])) w_hit[k] = 1'b1;
      for (int r = 0; r < RECENT; r++)
        if (r_recent_vld[r] && (r_recent[r] == w_line[k])) w_hit[k] = 1'b1;
      if (w_cand[k] && !w_hit[k] && (c_cnt_w'(w_n_acc) < w_free)) begin
        w_acc[k]      = 1'b1;
        w_slot_ptr[k] = r_wr_ptr + c_ptr_w'(w_n_acc);
        w_n_acc       = w_n_acc + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (w_acc[k]) r_mem[w_slot_ptr[k]] <= w_line[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_recent_vld <= '0;
      r_recent_ptr <= '0;
      r_last       <= '0;
      for (int r = 0; r < RECENT; r++) r_recent[r] <= '0;
    end else begin
      r_last <= req_addr_o;
      if (flush_i) begin
        r_rd_ptr     <= '0;
        r_wr_ptr     <= '0;
        r_count      <= '0;
        r_recent_vld <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(w_n_acc);
        r_count  <= r_count + c_cnt_w'(w_n_acc) - c_cnt_w'(w_pop);
        if (w_pop) begin
          r_rd_ptr                   <= r_rd_ptr + 1'b1;
          r_recent[r_recent_ptr]     <= w_head;
          r_recent_vld[r_recent_ptr] <= 1'b1;
          r_recent_ptr <= (r_recent_ptr == c_rec_w'(RECENT-1)) ? '0 : r_recent_ptr + 1'b1;
        end
      end
    end
  end

`ifdef PREF_STATS_EN
  logic [31:0] r_issued;
  logic [31:0] r_drop_dup;
  logic [31:0] r_drop_full;
  logic [2:0]  w_dup;
  logic [2:0]  w_drop_full;
  logic [1:0]  w_n_dup;
  logic [1:0]  w_n_full;
  logic [32:0] w_dup_sum;
  logic [32:0] w_full_sum;

  assign w_dup       = w_cand & w_hit;
  assign w_drop_full = w_cand & ~w_hit & ~w_acc;
  assign w_n_dup     = {1'b0, w_dup[0]} + {1'b0, w_dup[1]} + {1'b0, w_dup[2]};
  assign w_n_full    = {1'b0, w_drop_full[0]} + {1'b0, w_drop_full[1]} + {1'b0, w_drop_full[2]};
  assign w_dup_sum   = {1'b0, r_drop_dup} + 33'(w_n_dup);
  assign w_full_sum  = {1'b0, r_drop_full} + 33'(w_n_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued    <= '0;
      r_drop_dup  <= '0;
      r_drop_full <= '0;
    end else begin
      if (w_pop && (r_issued != '1)) r_issued <= r_issued + 32'd1;
      r_drop_dup  <= w_dup_sum[32]  ? '1 : w_dup_sum[31:0];
      r_drop_full <= w_full_sum[32] ? '1 : w_full_sum[31:0];
    end
  end

  assign stat_issued_o    = r_issued;
  assign stat_drop_dup_o  = r_drop_dup;
  assign stat_drop_full_o = r_drop_full;
`else
  assign stat_issued_o    = '0;
  assign stat_drop_dup_o  = '0;
  assign stat_drop_full_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pref_issue_queue.sv
//==============================================================================
// Module      : tb_pref_issue_queue
// Description : Vector table plus queue scoreboard for pref_issue_queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pref_issue_queue;

  localparam int AW    = 64;
  localparam int DEPTH = 8;
`ifdef PREF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_i = 1'b1;
  logic          flush_i = 1'b0;
  logic [AW-1:0] pref_addr1_i = '0, pref_addr2_i = '0, pref_addr3_i = '0;
  logic          pref_valid1_i = 1'b0, pref_valid2_i = 1'b0, pref_valid3_i = 1'b0;
  logic          req_valid_o;
  logic [AW-1:0] req_addr_o;
  logic          req_ready_i = 1'b0;
  logic [3:0]    occupancy_o;
  logic [31:0]   stat_issued_o, stat_drop_dup_o, stat_drop_full_o;

  always #5 clk = ~clk;

  pref_issue_queue dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .flush_i(flush_i),
    .pref_addr1_i(pref_addr1_i), .pref_addr2_i(pref_addr2_i), .pref_addr3_i(pref_addr3_i),
    .pref_valid1_i(pref_valid1_i), .pref_valid2_i(pref_valid2_i), .pref_valid3_i(pref_valid3_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .occupancy_o(occupancy_o), .stat_issued_o(stat_issued_o),
    .stat_drop_dup_o(stat_drop_dup_o), .stat_drop_full_o(stat_drop_full_o)
  );

  typedef struct {
    logic [2:0]  v;
    logic [63:0] a1, a2, a3;
    logic        rdy, en, fl;
    int          occ;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] m_q[$];
  logic [63:0] m_rec[$];
  logic [63:0] m_last;
  int unsigned m_iss, m_dup, m_full;
  int          n_chk, n_fail;
  int          rst_at;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned x);
    return (x == 32'hFFFF_FFFF) ? x : x + 1;
  endfunction

  task automatic add(input logic [2:0] v, input logic [63:0] a1, input logic [63:0] a2,
                     input logic [63:0] a3, input logic rdy, input logic en,
                     input logic fl, input int occ);
    vec_t t;
    t.v = v; t.a1 = a1; t.a2 = a2; t.a3 = a3;
    t.rdy = rdy; t.en = en; t.fl = fl; t.occ = occ;
    vecs.push_back(t);
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] ea;
    ea = (m_q.size() != 0) ? m_q[0] : m_last;
    chk({tag, "_occ"}, 64'(occupancy_o), 64'(m_q.size()));
    chk({tag, "_valid"}, 64'(req_valid_o), 64'(m_q.size() != 0));
    chk({tag, "_addr"}, req_addr_o, ea);
    chk({tag, "_issued"}, 64'(stat_issued_o), STATS ? 64'(m_iss) : 64'd0);
    chk({tag, "_dup"}, 64'(stat_drop_dup_o), STATS ? 64'(m_dup) : 64'd0);
    chk({tag, "_full"}, 64'(stat_drop_full_o), STATS ? 64'(m_full) : 64'd0);
    m_last = ea;
  endtask

  // Drive one cycle of stimulus, predict it, then compare after the edge.
  task automatic apply(input vec_t t);
    logic [63:0] a [3];
    logic [63:0] seen[$];
    logic [63:0] acc[$];
    logic [63:0] line, popped;
    bit          pop, dup;
    int          free;
    a = '{t.a1, t.a2, t.a3};
    pref_addr1_i = t.a1; pref_addr2_i = t.a2; pref_addr3_i = t.a3;
    pref_valid1_i = t.v[0]; pref_valid2_i = t.v[1]; pref_valid3_i = t.v[2];
    req_ready_i = t.rdy; enable_i = t.en; flush_i = t.fl;
    pop  = t.rdy && (m_q.size() != 0);
    if (pop) chk("issue_addr", req_addr_o, m_q[0]);
    free = DEPTH - m_q.size();
    if (t.en && !t.fl) begin
      for (int k = 0; k < 3; k++) begin
        if (t.v[k]) begin
          line = a[k] & ~64'h3F;
          dup  = 1'b0;
          foreach (seen[i]) if (seen[i] == line) dup = 1'b1;
          foreach (m_q[i])  if (m_q[i] == line)  dup = 1'b1;
          foreach (m_rec[i]) if (m_rec[i] == line) dup = 1'b1;
          seen.push_back(line);
          if (dup) m_dup = sat_inc(m_dup);
          else if (acc.size() < free) acc.push_back(line);
          else m_full = sat_inc(m_full);
        end
      end
    end
    @(posedge clk); #1;
    if (pop) begin
      popped = m_q.pop_front();
      m_iss  = sat_inc(m_iss);
      if (!t.fl) begin
        m_rec.push_back(popped);
        if (m_rec.size() > 4) void'(m_rec.pop_front());
      end
    end
    if (t.fl) begin
      m_q.delete();
      m_rec.delete();
    end else begin
      foreach (acc[i]) m_q.push_back(acc[i]);
    end
    chk("table_occ", 64'(occupancy_o), 64'(t.occ));
    check_outputs("cyc");
  endtask

  task automatic async_reset();
    pref_valid1_i = 1'b0; pref_valid2_i = 1'b0; pref_valid3_i = 1'b0;
    req_ready_i = 1'b0; flush_i = 1'b0; enable_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(req_valid_o), 64'd0);
    chk("rst_occ", 64'(occupancy_o), 64'd0);
    chk("rst_addr", req_addr_o, 64'd0);
    chk("rst_issued", 64'(stat_issued_o), 64'd0);
    chk("rst_dup", 64'(stat_drop_dup_o), 64'd0);
    chk("rst_full", 64'(stat_drop_full_o), 64'd0);
    m_q.delete(); m_rec.delete();
    m_iss = 0; m_dup = 0; m_full = 0; m_last = '0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs("post_rst");
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    m_iss = 0; m_dup = 0; m_full = 0; m_last = '0;

    // single issue
    add(3'b001, 64'h1039, 0, 0, 1, 1, 0, 1);
    add(3'b000, 0, 0, 0, 1, 1, 0, 0);
    add(3'b000, 0, 0, 0, 1, 1, 0, 0);
    // same-cycle duplicate
    add(3'b111, 64'h2000, 64'h2010, 64'h2040, 0, 1, 0, 2);
    add(3'b000, 0, 0, 0, 1, 1, 0, 1);
    add(3'b000, 0, 0, 0, 1, 1, 0, 0);
    // fill to full under back-pressure, then drain
    add(3'b111, 64'h10000, 64'h10040, 64'h10080, 0, 1, 0, 3);
    add(3'b111, 64'h100C0, 64'h10100, 64'h10140, 0, 1, 0, 6);
    add(3'b111, 64'h10180, 64'h101C0, 64'h10200, 0, 1, 0, 8);
    for (int i = 7; i >= 0; i--) add(3'b000, 0, 0, 0, 1, 1, 0, i);
    // recent filter hit, then eviction after four more issues
    add(3'b001, 64'h3000, 0, 0, 1, 1, 0, 1);
    add(3'b000, 0, 0, 0, 1, 1, 0, 0);
    add(3'b001, 64'h3000, 0, 0, 1, 1, 0, 0);
    add(3'b111, 64'h4000, 64'h4040, 64'h4080, 1, 1, 0, 3);
    add(3'b001, 64'h40C0, 0, 0, 1, 1, 0, 3);
    for (int i = 2; i >= 0; i--) add(3'b000, 0, 0, 0, 1, 1, 0, i);
    add(3'b001, 64'h3000, 0, 0, 1, 1, 0, 1);
    add(3'b000, 0, 0, 0, 1, 1, 0, 0);
    // flush with a candidate present, then a previously issued line
    add(3'b111, 64'h5040, 64'h5080, 64'h50C0, 0, 1, 0, 3);
    add(3'b011, 64'h5100, 64'h5140, 0, 0, 1, 0, 5);
    add(3'b001, 64'h5000, 0, 0, 0, 1, 1, 0);
    add(3'b001, 64'h40C0, 0, 0, 1, 1, 0, 1);
    add(3'b000, 0, 0, 0, 1, 1, 0, 0);
    // disabled input
    add(3'b111, 64'h6000, 64'h6040, 64'h6080, 1, 0, 0, 0);
    // flush while handshaking
    add(3'b011, 64'h7000, 64'h7040, 0, 0, 1, 0, 2);
    add(3'b000, 0, 0, 0, 1, 1, 1, 0);
    add(3'b001, 64'h7000, 0, 0, 1, 1, 0, 1);
    add(3'b000, 0, 0, 0, 1, 1, 0, 0);
    // slot 3 duplicates slot 2 within a line
    add(3'b110, 0, 64'h8100, 64'h8104, 0, 1, 0, 1);
    add(3'b000, 0, 0, 0, 1, 1, 0, 0);
    // four queued before async reset
    add(3'b111, 64'h8000, 64'h8040, 64'h8080, 0, 1, 0, 3);
    add(3'b001, 64'h80C0, 0, 0, 0, 1, 0, 4);
    rst_at = vecs.size();
    add(3'b000, 0, 0, 0, 1, 1, 0, 0);
    add(3'b001, 64'h8000, 0, 0, 1, 1, 0, 1);
    add(3'b000, 0, 0, 0, 1, 1, 0, 0);
    // full with a same-cycle dequeue: freed slot not reusable
    add(3'b111, 64'h9000, 64'h9040, 64'h9080, 0, 1, 0, 3);
    add(3'b111, 64'h90C0, 64'h9100, 64'h9140, 0, 1, 0, 6);
    add(3'b011, 64'h9180, 64'h91C0, 0, 0, 1, 0, 8);
    add(3'b001, 64'h9200, 0, 0, 1, 1, 0, 7);
    add(3'b001, 64'h9000, 0, 0, 1, 1, 0, 6);
    for (int i = 5; i >= 0; i--) add(3'b000, 0, 0, 0, 1, 1, 0, i);

    #1;
    chk("init_valid", 64'(req_valid_o), 64'd0);
    chk("init_occ", 64'(occupancy_o), 64'd0);
    chk("init_addr", req_addr_o, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs("idle");

    foreach (vecs[i]) begin
      if (i == rst_at) async_reset();
      apply(vecs[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/pref_issue_queue.md
Name: pref_issue_queue

Overview:
- Sits between the ip_stride prefetcher and the memory/L2 request port.
- Collects up to three prefetch candidates per cycle (ip_stride slots 1-3) and aligns them to cache lines.
- Filters duplicates against same-cycle slots, queued entries and recently issued lines.
- Buffers survivors in a FIFO and issues them one per cycle over a valid/ready handshake.

Parameters:
- ADDR_W, 64, address width.
- DEPTH, 8, FIFO entries; power of 2, >=4.
- LINE_BITS, 6, line offset bits zeroed before queuing (64 B lines).
- RECENT, 4, entries in the recently-issued filter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- enable_i  in  1  0: all incoming candidates ignored (not counted as drops).
- flush_i  in  1  clear FIFO and recent filter at next edge.
- pref_addr1_i / pref_addr2_i / pref_addr3_i  in  ADDR_W each  candidate addresses, slot 1 highest priority.
- pref_valid1_i / pref_valid2_i / pref_valid3_i  in  1 each  candidate valid.
- req_valid_o  out  1  request available.
- req_addr_o  out  ADDR_W  line-aligned request address.
- req_ready_i  in  1  downstream accepts; transfer when req_valid_o && req_ready_i.
- occupancy_o  out  $clog2(DEPTH)+1  entries held.
- stat_issued_o  out  32  transfers completed.
- stat_drop_dup_o  out  32  candidates dropped as duplicates.
- stat_drop_full_o  out  32  candidates dropped for lack of space.

Behaviour:
- Reset (rst_n low, async): FIFO pointers/count = 0, recent filter invalid, counters = 0. req_valid_o = 0, req_addr_o = 0, occupancy_o = 0, stat_* = 0 immediately.
- Line address = candidate with low LINE_BITS forced to 0.
- Candidates are evaluated in slot order 1, 2, 3. A candidate is a duplicate if its line matches:
  - an earlier valid slot this cycle, or
  - any valid FIFO entry, including the head being dequeued this cycle, or
  - any valid recent-filter entry.
- free = DEPTH - occupancy, sampled before this cycle's dequeue; a slot freed by a same-cycle dequeue is not reusable that cycle.
- Non-duplicates are enqueued in slot order while free > 0. The remainder are dropped_full.
- Duplicate check takes precedence over the full check: a duplicate counts only as drop_dup.
- Latency: a candidate presented at edge N appears at req_addr_o after edge N (1 cycle) if the FIFO was empty.
- Output: req_valid_o = (occupancy != 0); req_addr_o = head entry, driven from registered storage.
- req_addr_o is held stable while req_valid_o && !req_ready_i.
- req_addr_o retains its last value when empty; no X.
- On transfer:
  - head pops;
  - line is written into the recent filter, round-robin replacing the oldest entry;
  - stat_issued_o increments.
- Simultaneous enqueue (up to 3) and dequeue in one cycle: occupancy_next = occupancy + accepted - popped.
- Pointers wrap modulo DEPTH.
- enable_i = 0: candidates ignored; dequeue continues normally.
- flush_i = 1 at an edge:
  - FIFO emptied and recent filter invalidated;
  - same-cycle candidates ignored (no counts);
  - a transfer handshaking in that cycle still completes and counts as issued.
  - The next cycle has req_valid_o = 0.
- Counters saturate at 32'hFFFF_FFFF. Counters are not cleared by flush.

Optional Feature:
- PREF_STATS_EN defined: the three stat counters are implemented as above.
- Not defined: counter registers are removed; stat_*_o tied to 0. Port list is unchanged and queue behaviour is identical.

Test Plan:
- Single issue: ready=1, slot1 valid addr 0x1039 for one cycle -> next cycle req_valid_o=1, req_addr_o=0x1000 for exactly one cycle; stat_issued_o=1.
- Same-cycle duplicates: ready=0, slots 0x2000/0x2010/0x2040 -> occupancy 2. Then ready=1 -> issues 0x2000 then 0x2040; stat_drop_dup_o=1.
- Full and back-pressure: DEPTH=8, ready=0, three distinct lines per cycle for 3 cycles -> occupancy 8, stat_drop_full_o=1 (cycle-3 slot 3), req_addr_o constant = first line.
- Recent filter: issue 0x3000, then present 0x3000 -> dropped, drop_dup +1. After 4 further distinct issues, present 0x3000 -> accepted and issued.
- Flush: ready=0, queue 5 lines, pulse flush_i with slot1 = 0x5000 -> next cycle occupancy 0, req_valid_o=0, no count change. Re-present a previously issued line -> accepted.
- Async reset mid-operation: 4 queued, drive rst_n low between edges -> req_valid_o, occupancy_o, stat_* are 0 before the next edge. Release -> idle.
